spi_word_receiver: RTL and testbench
====================================

// Module: spi_word_receiver
// PURPOSE
//  SPI slave front end (mode 0, MSB first) between the host MCU and the settings register file.
//  Oversamples the sck/cs_n/sdi pins in the clk domain and deserialises 16-bit command words.
//  Presents each complete word on word_out, held stable until the next word completes.
//  word_out drives the settings register file's 16-bit data input; bits [15:12] select the register.
// PARAMETERS
//  WORD_W       16        bits per command word
//  SYNC_STAGES  2         flops in each pin synchroniser (min 2)
//  IDLE_WORD    16'hF000  word_out value after reset; address 0xF decodes to no register
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-low reset
//  sck         in   1       SPI clock pin, async; f_sck <= f_clk/4
//  cs_n        in   1       SPI chip select pin, active low, async
//  sdi         in   1       SPI data in (MOSI), async
//  sdo         out  1       SPI data out (MISO); see CONFIGURATION
//  word_out    out  WORD_W  last complete word, held
//  word_valid  out  1       1-cycle pulse on the cycle word_out updates
//  frame_err   out  1       1-cycle pulse when cs_n rises with a partial word pending
// BEHAVIOUR
//  Reset (rst=0 at posedge clk): word_out=IDLE_WORD, word_valid=0, frame_err=0, sdo=0,
//   shift reg=0, bit_cnt=0, synchroniser flops=idle levels (sck 0, cs_n 1), state=WAIT_IDLE.
//  Sync: sck, cs_n, sdi each pass SYNC_STAGES flops plus one history flop for edge detection.
//   rise = sck_s & ~sck_d; fall = ~sck_s & sck_d. sdi sampled from its synchronised copy
//   on the rise cycle (same pipeline depth as sck, so data aligns with edge).
//  FSM:
//   WAIT_IDLE: ignore sck; -> READY when cs_n_s==1. Entered from reset so that a frame already
//    in progress at reset release is discarded entirely.
//   READY: bit_cnt=0; -> SHIFT when cs_n_s==0.
//   SHIFT: on rise: shift={shift[WORD_W-2:0],sdi_s}, bit_cnt+=1.
//    When bit_cnt==WORD_W-1 on a rise: word_out<=new shift value, word_valid=1 next cycle,
//    bit_cnt wraps to 0, stay in SHIFT (back-to-back words in one frame allowed).
//    On cs_n_s==1: -> READY; if bit_cnt!=0 pulse frame_err, partial word discarded,
//    word_out unchanged.
//  Simultaneous: rise and cs_n_s rise in same cycle -> rise processed first
//   (16th bit completes word, word_valid=1, no frame_err); then -> READY.
//  Latency: word_out/word_valid update SYNC_STAGES+2 clk cycles after the 16th sck pin rise.
//  word_valid and frame_err never assert in the same cycle.
//  No rise events while cs_n_s==1 alter any state; sck activity outside a frame is ignored.
//  rst mid-frame: all state cleared, -> WAIT_IDLE; remaining bits of that frame dropped.
// CONFIGURATION
//  SPI_ECHO_EN defined: sdo shifts out the previous word_out, MSB first, during each word.
//   At frame/word start sdo = echo[WORD_W-1]; each fall advances echo by one bit.
//   echo reg loaded from word_out on entry to SHIFT and on every word wrap.
//   sdo=0 whenever cs_n_s==1. Host reads back the last accepted command.
//  SPI_ECHO_EN undefined: sdo tied 0; no echo register synthesised.
// TESTING
//  Reset release, no SPI traffic -> word_out==16'hF000, word_valid/frame_err stay 0.
//  One frame of 16'h0A53 (f_sck=f_clk/8) -> one word_valid pulse, word_out==16'h0A53,
//   pulse exactly SYNC_STAGES+2 cycles after 16th sck rise.
//  One cs_n frame with 16'h1267 then 16'h2F80 -> two word_valid pulses,
//   word_out==16'h1267 then 16'h2F80; no frame_err.
//  Frame aborted after 9 bits -> frame_err pulse, word_out unchanged; next full 16'h0123 accepted.
//  rst asserted after bit 5, released while cs_n still low, rest of frame clocked ->
//   no word_valid; next full frame 16'h0456 accepted.
//  SPI_ECHO_EN: send 16'h0A53 then 16'h1267 -> sdo bits during second word read 16'h0A53;
//   without macro sdo constant 0.

Source files
------------

// File: rtl/spi_word_receiver.sv
// SPI mode-0 slave deserialiser: oversamples sck/cs_n/sdi in the clk domain and emits 16-bit words.
// Optional readback of the previous word on sdo is enabled by defining SPI_ECHO_EN.
module spi_word_receiver #(
  parameter int                WORD_W      = 16,
  parameter int                SYNC_STAGES = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD   = 16'hF000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              sdi,
  output logic              sdo,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WORD_W - 1);
  localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    READY     = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r, cs_sync_r, sdi_sync_r;
  logic                   sck_d_r;
  logic                   sck_s, cs_n_s, sdi_s, rise_s;

  state_t                 state_r, state_n;
  logic [WORD_W-1:0]      shift_r, shift_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [SET_W-1:0]       settle_r, settle_n;
  logic                   done_r, done_n;
  logic                   err_r, err_n;
  logic                   sdo_n;

  assign sck_s  = sck_sync_r[SYNC_STAGES-1];
  assign cs_n_s = cs_sync_r[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_r[SYNC_STAGES-1];
  assign rise_s = sck_s & ~sck_d_r;

  // Pin synchronisers plus the sck history flop used for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync_r <= '0;
      cs_sync_r  <= '1;
      sdi_sync_r <= '0;
      sck_d_r    <= 1'b0;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
      sck_d_r    <= sck_s;
    end
  end

  // Next-state logic. WAIT_IDLE first lets the synchronisers refill with real pin
  // samples, otherwise their reset-high cs_n would let a running frame slip in.
  always_comb begin
    state_n  = state_r;
    shift_n  = shift_r;
    cnt_n    = cnt_r;
    settle_n = settle_r;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if (settle_r != SETTLE_DONE) begin
          settle_n = settle_r + SET_W'(1);
        end else if (cs_n_s) begin
          state_n = READY;
        end else begin
          state_n = WAIT_IDLE;
        end
      end
      READY: begin
        cnt_n = '0;
        if (!cs_n_s) begin
          state_n = SHIFT;
        end else begin
          state_n = READY;
        end
      end
      SHIFT: begin
        // A rise coinciding with cs_n release is consumed before the frame closes.
        if (rise_s) begin
          shift_n = {shift_r[WORD_W-2:0], sdi_s};
          if (cnt_r == CNT_LAST) begin
            cnt_n  = '0;
            done_n = 1'b1;
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end else begin
          shift_n = shift_r;
        end
        if (cs_n_s) begin
          state_n = READY;
          err_n   = (cnt_n != '0);
        end else begin
          state_n = SHIFT;
        end
      end
      default: begin
        state_n = WAIT_IDLE;
      end
    endcase
  end

`ifdef SPI_ECHO_EN
  logic [WORD_W-1:0] echo_r, echo_n;
  logic              echo_hold_r, echo_hold_n;
  logic              fall_s;

  assign fall_s = ~sck_s & sck_d_r;

  // Echo shifter. After a word wrap the trailing sck fall of the finished word must
  // not consume the new MSB, so the reload arms a one-fall hold.
  always_comb begin
    echo_n      = echo_r;
    echo_hold_n = echo_hold_r;
    if ((state_r == READY) && (state_n == SHIFT)) begin
      echo_n      = word_out;
      echo_hold_n = 1'b0;
    end else if ((state_r == SHIFT) && done_n) begin
      echo_n      = shift_n;
      echo_hold_n = 1'b1;
    end else if ((state_r == SHIFT) && fall_s) begin
      if (echo_hold_r) begin
        echo_hold_n = 1'b0;
      end else begin
        echo_n = {echo_r[WORD_W-2:0], 1'b0};
      end
    end else begin
      echo_n = echo_r;
    end
    sdo_n = ((state_n == SHIFT) && !cs_n_s) ? echo_n[WORD_W-1] : 1'b0;
  end

  // Echo state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      echo_r      <= '0;
      echo_hold_r <= 1'b0;
    end else begin
      echo_r      <= echo_n;
      echo_hold_r <= echo_hold_n;
    end
  end
`else
  assign sdo_n = 1'b0;
`endif

  // FSM state and registered outputs; word_out copies the completed shift value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= WAIT_IDLE;
      shift_r    <= '0;
      cnt_r      <= '0;
      settle_r   <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      word_out   <= IDLE_WORD;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      sdo        <= 1'b0;
    end else begin
      state_r    <= state_n;
      shift_r    <= shift_n;
      cnt_r      <= cnt_n;
      settle_r   <= settle_n;
      done_r     <= done_n;
      err_r      <= err_n;
      word_valid <= done_r;
      frame_err  <= err_r;
      sdo        <= sdo_n;
      if (done_r) begin
        word_out <= shift_r;
      end else begin
        word_out <= word_out;
      end
    end
  end

endmodule

// File: tb/tb_spi_word_receiver.sv
// Scoreboard bench for spi_word_receiver: directed SPI frames at f_sck = f_clk/8.
// Echo expectations follow SPI_ECHO_EN when that macro is defined for the build.
module tb_spi_word_receiver;

  localparam int SYNC = 2;
  localparam int HALF = 4;
`ifdef SPI_ECHO_EN
  localparam logic [15:0] ECHO_FIRST  = 16'h0456;
  localparam logic [15:0] ECHO_SECOND = 16'h0A53;
`else
  localparam logic [15:0] ECHO_FIRST  = 16'h0000;
  localparam logic [15:0] ECHO_SECOND = 16'h0000;
`endif

  logic        clk, rst, sck, cs_n, sdi, sdo;
  logic [15:0] word_out;
  logic        word_valid, frame_err;

  typedef struct {
    logic        is_err;
    logic [15:0] word;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc    = 0;
  logic [15:0] rx;

  spi_word_receiver #(.WORD_W(16), .SYNC_STAGES(SYNC), .IDLE_WORD(16'hF000)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
    .word_out(word_out), .word_valid(word_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clock nbits of w MSB first; capture sdo just before each rise.
  task automatic send_word(input logic [15:0] w, input int nbits, input bit push,
                           input bit cs_with_last, output logic [15:0] echo_rx);
    exp_t e;
    echo_rx = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      sdi = w[15-i];
      tick(HALF);
      echo_rx = {echo_rx[14:0], sdo};
      sck = 1'b1;
      if (cs_with_last && (i == nbits - 1)) cs_n = 1'b1;
      if (push && (i == 15)) begin
        e.is_err = 1'b0;
        e.word   = w;
        e.due    = cyc + SYNC + 2;
        exp_q.push_back(e);
      end
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic frame_start;
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic frame_end;
    tick(HALF);
    cs_n = 1'b1;
    tick(12);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (word_valid && frame_err) check("valid_and_err_together", 32'd1, 32'd0);
    if (word_valid || frame_err) begin
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pulse_kind_is_err", 32'(frame_err), 32'(e.is_err));
        check("word_out", 32'(word_out), 32'(e.word));
        if (e.due >= 0) check("valid_latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b0; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    tick(3);
    check("reset_word_out", 32'(word_out), 32'h0000F000);
    check("reset_word_valid", 32'(word_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_sdo", 32'(sdo), 32'd0);
    rst = 1'b1;
    tick(20);
    check("idle_word_out", 32'(word_out), 32'h0000F000);

    frame_start;
    send_word(16'h0A53, 16, 1'b1, 1'b0, rx);
    frame_end;

    frame_start;
    send_word(16'h1267, 16, 1'b1, 1'b0, rx);
    send_word(16'h2F80, 16, 1'b1, 1'b0, rx);
    frame_end;

    // Aborted after 9 bits: error pulse while word_out keeps the last word.
    frame_start;
    send_word(16'hABCD, 9, 1'b0, 1'b0, rx);
    e.is_err = 1'b1; e.word = 16'h2F80; e.due = -1;
    exp_q.push_back(e);
    frame_end;
    frame_start;
    send_word(16'h0123, 16, 1'b1, 1'b0, rx);
    frame_end;

    // Reset mid-frame: the remainder of that frame must be dropped.
    frame_start;
    send_word(16'h5A5A, 5, 1'b0, 1'b0, rx);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    send_word(16'hFFFF, 11, 1'b0, 1'b0, rx);
    frame_end;
    check("word_out_after_midframe_reset", 32'(word_out), 32'h0000F000);
    frame_start;
    send_word(16'h0456, 16, 1'b1, 1'b0, rx);
    frame_end;

    frame_start;
    send_word(16'h0A53, 16, 1'b1, 1'b0, rx);
    frame_end;
    check("sdo_readback_first", 32'(rx), 32'(ECHO_FIRST));
    frame_start;
    send_word(16'h1267, 16, 1'b1, 1'b0, rx);
    frame_end;
    check("sdo_readback_second", 32'(rx), 32'(ECHO_SECOND));

    // 16th rise coincides with cs_n release, then sck toggles outside any frame.
    frame_start;
    send_word(16'h3C5A, 16, 1'b1, 1'b1, rx);
    tick(12);
    for (int k = 0; k < 3; k++) begin
      sdi = 1'b1;
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    tick(12);
    check("word_out_after_stray_sck", 32'(word_out), 32'h00003C5A);

    tick(20);
    check("expectations_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
